jtag_tap_slave: RTL and testbench



---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_tap_fsm.sv | 65 ++++++
 rtl/jtag_tap_slave.sv | 123 ++++++++++++
 tb/tb_jtag_tap_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_pkg: TAP state encoding, opcodes and IR capture pattern.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PA_IR  = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_e;

  localparam int IR_WIDTH_DEFAULT = 4;

  // Sized at the default IR width; instantiating modules resize to their own.
  localparam logic [IR_WIDTH_DEFAULT-1:0] IR_IDCODE = 4'h1;
  localparam logic [IR_WIDTH_DEFAULT-1:0] IR_USER   = 4'h2;
  localparam logic [IR_WIDTH_DEFAULT-1:0] IR_BYPASS = 4'hF;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller with state strobes.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_e r_state;
  tap_state_e w_next_state;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) r_state <= TLR;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = TLR;
    case (r_state)
      TLR:     w_next_state = tms ? TLR    : RTI;
      RTI:     w_next_state = tms ? SEL_DR : RTI;
      SEL_DR:  w_next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_next_state = tms ? EX1_DR : SH_DR;
      SH_DR:   w_next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_next_state = tms ? UPD_DR : PA_DR;
      PA_DR:   w_next_state = tms ? EX2_DR : PA_DR;
      EX2_DR:  w_next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_next_state = tms ? SEL_DR : RTI;
      SEL_IR:  w_next_state = tms ? TLR    : CAP_IR;
      CAP_IR:  w_next_state = tms ? EX1_IR : SH_IR;
      SH_IR:   w_next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_next_state = tms ? UPD_IR : PA_IR;
      PA_IR:   w_next_state = tms ? EX2_IR : PA_IR;
      EX2_IR:  w_next_state = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_next_state = tms ? SEL_DR : RTI;
      default: w_next_state = TLR;
    endcase
  end

  always_comb begin
    state      = r_state;
    capture_dr = (r_state == CAP_DR);
    shift_dr   = (r_state == SH_DR);
    update_dr  = (r_state == UPD_DR);
    capture_ir = (r_state == CAP_IR);
    shift_ir   = (r_state == SH_IR);
    update_ir  = (r_state == UPD_IR);
    tlr        = (r_state == TLR);
  end

endmodule
`default_nettype wire

// File: rtl/jtag_tap_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_tap_slave: TAP responder with IR, BYPASS, IDCODE and USER DRs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtag_tap_slave
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B,
  parameter int          USER_WIDTH = 16
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tdi,
  input  logic                  tms,
  output logic                  tdo,
  output logic                  tdo_en,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update,
  output logic [IR_WIDTH-1:0]   ir_out
);

  localparam logic [IR_WIDTH-1:0] c_ir_idcode  = IR_WIDTH'(IR_IDCODE);
  localparam logic [IR_WIDTH-1:0] c_ir_user    = IR_WIDTH'(IR_USER);
  localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(IR_CAPTURE);

  tap_state_e w_state;
  logic w_capture_dr, w_shift_dr, w_update_dr;
  logic w_capture_ir, w_shift_ir, w_update_ir, w_tlr;
  logic w_sel_id, w_sel_user, w_tdo_mux;

  logic [IR_WIDTH-1:0]   r_ir, r_ir_sr;
  logic [31:0]           r_id_sr;
  logic [USER_WIDTH-1:0] r_user_sr, r_user_out;
  logic                  r_bypass, r_user_update, r_tdo, r_tdo_en;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (w_state),
    .capture_dr (w_capture_dr),
    .shift_dr   (w_shift_dr),
    .update_dr  (w_update_dr),
    .capture_ir (w_capture_ir),
    .shift_ir   (w_shift_ir),
    .update_ir  (w_update_ir),
    .tlr        (w_tlr)
  );

  // The instruction reads as IDCODE the moment TLR is entered, not one tck later.
  assign ir_out      = w_tlr ? c_ir_idcode : r_ir;
  assign w_sel_id    = (ir_out == c_ir_idcode);
  assign w_sel_user  = (ir_out == c_ir_user);
  assign user_dr_out = r_user_out;
  assign user_update = r_user_update;
  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_ir    <= c_ir_idcode;
      r_ir_sr <= '0;
    end else begin
      if (w_tlr)            r_ir <= c_ir_idcode;
      else if (w_update_ir) r_ir <= r_ir_sr;
      if (w_capture_ir)     r_ir_sr <= c_ir_capture;
      else if (w_shift_ir)  r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Unselected data registers are left untouched by capture and shift.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_id_sr   <= '0;
      r_user_sr <= '0;
      r_bypass  <= 1'b0;
    end else if (w_capture_dr) begin
      if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
      else if (w_sel_user) r_user_sr <= user_dr_in;
      else                 r_bypass  <= 1'b0;
    end else if (w_shift_dr) begin
      if (w_sel_id)        r_id_sr   <= {tdi, r_id_sr[31:1]};
      else if (w_sel_user) r_user_sr <= {tdi, r_user_sr[USER_WIDTH-1:1]};
      else                 r_bypass  <= tdi;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_user_out    <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= w_update_dr && w_sel_user;
      if (w_update_dr && w_sel_user) r_user_out <= r_user_sr;
    end
  end

  always_comb begin
    w_tdo_mux = 1'b0;
    if (w_state == SH_IR) begin
      w_tdo_mux = r_ir_sr[0];
    end else if (w_state == SH_DR) begin
      if (w_sel_id)        w_tdo_mux = r_id_sr[0];
      else if (w_sel_user) w_tdo_mux = r_user_sr[0];
      else                 w_tdo_mux = r_bypass;
    end
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_mux;
      r_tdo_en <= (w_state == SH_DR) || (w_state == SH_IR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_jtag_tap_slave: scoreboard bench for the JTAG TAP responder.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jtag_tap_slave;

  logic        tck = 1'b0;
  logic        trst, tdi, tms;
  logic        tdo, tdo_en, user_update;
  logic [15:0] user_dr_in, user_dr_out;
  logic [3:0]  ir_out;

  int total = 0;
  int bad   = 0;

  bit          tdo_q[$];
  logic [15:0] upd_q[$];
  bit          exp_bit;
  logic [15:0] exp_upd;

  localparam logic [31:0] c_idcode = 32'h1234_5A5B;

  jtag_tap_slave dut (
    .tck         (tck),
    .trst        (trst),
    .tdi         (tdi),
    .tms         (tms),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update),
    .ir_out      (ir_out)
  );

  always #5 tck = ~tck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Serial output monitor: every valid tdo bit must match the next queued bit.
  always @(negedge tck) begin
    #1;
    if (tdo_en === 1'b1) begin
      if (tdo_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tdo_unexpected: tdo_en=1 tdo=%b with no bit queued", tdo);
      end else begin
        exp_bit = tdo_q.pop_front();
        check("tdo_bit", 32'(tdo), 32'(exp_bit));
      end
    end
  end

  // Update monitor: each user_update cycle must match one queued write.
  always @(posedge tck) begin
    #3;
    if (user_update === 1'b1) begin
      if (upd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL user_update_unexpected: user_dr_out=%h", user_dr_out);
      end else begin
        exp_upd = upd_q.pop_front();
        check("user_dr_out_at_update", 32'(user_dr_out), 32'(exp_upd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic m, input logic d);
    @(negedge tck);
    #2;
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic goto_shift(input bit is_ir);
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic shift(input bit is_ir, input int n, input logic [31:0] din, input logic [31:0] exp);
    goto_shift(is_ir);
    for (int i = 0; i < n; i++) tdo_q.push_back(exp[i]);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("tdo_drained", 32'(tdo_q.size()), 32'd0);
  endtask

  task automatic shift_paused(input int n, input int k, input logic [31:0] din, input logic [31:0] exp);
    goto_shift(1'b0);
    for (int i = 0; i < n; i++) tdo_q.push_back(exp[i]);
    for (int i = 0; i < k; i++) step(i == k - 1, din[i]);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = k; i < n; i++) step(i == n - 1, din[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("tdo_drained_paused", 32'(tdo_q.size()), 32'd0);
  endtask

  initial begin
    trst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    user_dr_in = 16'h0000;
    repeat (3) @(posedge tck);
    #1;
    check("rst_tdo", 32'(tdo), 32'd0);
    check("rst_tdo_en", 32'(tdo_en), 32'd0);
    check("rst_ir_out", 32'(ir_out), 32'h1);
    check("rst_user_dr_out", 32'(user_dr_out), 32'h0);
    check("rst_user_update", 32'(user_update), 32'h0);
    @(negedge tck);
    #2;
    trst = 1'b0;
    step(1'b0, 1'b0);

    // IDCODE read straight out of reset
    shift(1'b0, 32, 32'h0, c_idcode);
    check("ir_after_idcode", 32'(ir_out), 32'h1);

    // IR capture pattern and load of BYPASS
    shift(1'b1, 4, 32'hF, 32'h1);
    check("ir_bypass", 32'(ir_out), 32'hF);
    shift(1'b0, 8, 32'h4D, 32'h9A);

    // Undefined opcode behaves as BYPASS
    shift(1'b1, 4, 32'h7, 32'h1);
    check("ir_undef", 32'(ir_out), 32'h7);
    shift(1'b0, 8, 32'h4D, 32'h9A);

    // USER write/read, straight and through the pause states
    shift(1'b1, 4, 32'h2, 32'h1);
    check("ir_user", 32'(ir_out), 32'h2);
    user_dr_in = 16'hBEEF;
    upd_q.push_back(16'hA5C3);
    shift(1'b0, 16, 32'hA5C3, 32'hBEEF);
    step(1'b0, 1'b0);
    check("user_dr_out_a", 32'(user_dr_out), 32'hA5C3);
    upd_q.push_back(16'hA5C3);
    shift_paused(16, 6, 32'hA5C3, 32'hBEEF);
    step(1'b0, 1'b0);
    check("user_dr_out_paused", 32'(user_dr_out), 32'hA5C3);

    // Zero-length DR scan writes the captured value
    user_dr_in = 16'h0F0F;
    upd_q.push_back(16'h0F0F);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("user_dr_out_zero_len", 32'(user_dr_out), 32'h0F0F);

    // Five tms=1 from mid IR shift reach TLR; USER output untouched
    goto_shift(1'b1);
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    check("tms_reset_ir_out", 32'(ir_out), 32'h1);
    check("tms_reset_user_dr_out", 32'(user_dr_out), 32'h0F0F);
    check("tms_reset_drained", 32'(tdo_q.size()), 32'd0);
    step(1'b0, 1'b0);

    // Async trst in the middle of a USER shift
    shift(1'b1, 4, 32'h2, 32'h1);
    user_dr_in = 16'hBEEF;
    goto_shift(1'b0);
    for (int i = 0; i < 5; i++) tdo_q.push_back(user_dr_in[i]);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    #1;
    trst = 1'b1;
    #1;
    check("trst_tdo", 32'(tdo), 32'd0);
    check("trst_tdo_en", 32'(tdo_en), 32'd0);
    check("trst_user_dr_out", 32'(user_dr_out), 32'h0);
    check("trst_ir_out", 32'(ir_out), 32'h1);
    check("trst_drained", 32'(tdo_q.size()), 32'd0);
    @(negedge tck);
    #2;
    tms = 1'b0;
    trst = 1'b0;
    step(1'b0, 1'b0);
    shift(1'b0, 32, 32'hFFFF_FFFF, c_idcode);

    repeat (3) step(1'b0, 1'b0);
    check("upd_q_drained", 32'(upd_q.size()), 32'd0);
    check("tdo_q_final", 32'(tdo_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
